// File: rtl/apb_pkg.sv
// Shared APB definitions: master FSM states, bus widths, slave register map and slave reset values.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAccess,
    StRdwait,
    StResp
  } apbm_state_e;

  localparam logic [APB_ADDR_W-1:0] ADDR_CNTRL = 'h0;
  localparam logic [APB_ADDR_W-1:0] ADDR_REG1  = 'h4;
  localparam logic [APB_ADDR_W-1:0] ADDR_REG2  = 'h8;
  localparam logic [APB_ADDR_W-1:0] ADDR_REG3  = 'hC;
  localparam logic [APB_ADDR_W-1:0] ADDR_REG4  = 'h10;

  localparam logic [APB_DATA_W-1:0] RST_CNTRL = 32'h0000_0000;
  localparam logic [APB_DATA_W-1:0] RST_REG1  = 32'h5A5A_5555;
  localparam logic [APB_DATA_W-1:0] RST_REG2  = 32'h0000_0000;
  localparam logic [APB_DATA_W-1:0] RST_REG3  = 32'hA5A5_0000;
  localparam logic [APB_DATA_W-1:0] RST_REG4  = 32'h0000_FFFF;

endpackage

// File: rtl/apb_cmd_master.sv
// Valid/ready command to APB SETUP/ACCESS master with delayed read-data capture.
// Optional address checking is enabled by defining APBM_ADDR_CHECK_EN.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int unsigned        ADDR_W   = APB_ADDR_W,
  parameter int unsigned        DATA_W   = APB_DATA_W,
  parameter int unsigned        RD_LAT   = 1,
  parameter logic [ADDR_W-1:0]  MAX_ADDR = 'h10
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata
);

`ifdef APBM_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  apbm_state_e state_q;
  logic [2:0]  cnt_q;
  logic        addr_bad;

  // Constant-folds to 0 when checking is disabled, leaving rsp_err stuck at 0.
  assign addr_bad = ADDR_CHECK && ((req_addr[1:0] != 2'b00) || (req_addr > MAX_ADDR));

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= StIdle;
      cnt_q     <= 3'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            pwrite    <= req_write;
            paddr     <= req_addr;
            pwdata    <= req_wdata;
            if (addr_bad) begin
              state_q   <= StResp;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state_q <= StSetup;
              psel    <= 1'b1;
            end
          end
        end
        StSetup: begin
          penable <= 1'b1;
          state_q <= StAccess;
        end
        StAccess: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          if (pwrite) begin
            state_q   <= StResp;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            state_q <= StRdwait;
            cnt_q   <= 3'(RD_LAT);
          end
        end
        StRdwait: begin
          cnt_q <= cnt_q - 3'd1;
          // The slave's registered data is valid on the edge the counter hits zero.
          if (cnt_q == 3'd1) begin
            state_q   <= StResp;
            rsp_valid <= 1'b1;
            rsp_rdata <= prdata;
          end
        end
        StResp: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a behavioural APB register slave (RD_LAT=1).
module tb_apb_cmd_master;
  import apb_pkg::*;

  logic        pclk = 1'b0;
  logic        preset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;

  int vectors = 0;
  int errors  = 0;
  int acc_cnt = 0;
  int psel_run = 0;

  apb_cmd_master #(.RD_LAT(1)) dut (
    .pclk      (pclk),
    .preset    (preset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata)
  );

  always #5 pclk = ~pclk;

  // Register slave: REG1 read-only, unmapped reads return 0, read data registered at ACCESS.
  logic [31:0] sregs [5];

  function automatic int reg_idx(input logic [31:0] a);
    case (a)
      ADDR_CNTRL: return 0;
      ADDR_REG1:  return 1;
      ADDR_REG2:  return 2;
      ADDR_REG3:  return 3;
      ADDR_REG4:  return 4;
      default:    return -1;
    endcase
  endfunction

  always @(posedge pclk) begin
    if (preset) begin
      sregs[0] <= RST_CNTRL;
      sregs[1] <= RST_REG1;
      sregs[2] <= RST_REG2;
      sregs[3] <= RST_REG3;
      sregs[4] <= RST_REG4;
      prdata   <= '0;
    end else if (psel && penable) begin
      if (pwrite) begin
        if (reg_idx(paddr) >= 0 && reg_idx(paddr) != 1) sregs[reg_idx(paddr)] <= pwdata;
      end else begin
        prdata <= (reg_idx(paddr) >= 0) ? sregs[reg_idx(paddr)] : 32'h0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus protocol watch: penable implies psel, psel runs of at most 2, no psel while ready.
  always @(negedge pclk) begin
    if (preset) begin
      psel_run = 0;
    end else begin
      if (psel && penable) acc_cnt++;
      psel_run = psel ? psel_run + 1 : 0;
      check("penable_wo_psel", 32'(penable && !psel), 32'h0);
      check("psel_run_le2", 32'(psel_run > 2), 32'h0);
      check("ready_with_psel", 32'(req_ready && psel), 32'h0);
    end
  end

  // Caller is at #1 after an edge with the DUT in IDLE or RESP; returns in the RESP cycle.
  task automatic do_cmd(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input int exp_lat, input logic exp_err, input bit hold);
    int n;
    int lat;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 8) begin
      @(posedge pclk); #1;
      n++;
    end
    check({tag, " ready"}, 32'(req_ready), 32'h1);
    if (hold) check({tag, " accept_first_idle"}, 32'(n <= 1), 32'h1);
    acc_cnt = 0;
    @(posedge pclk); #1;
    if (hold) begin
      req_write = ~wr;
      req_addr  = ~addr;
      req_wdata = ~wdata;
    end else begin
      req_valid = 1'b0;
    end
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge pclk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " rdata"}, rsp_rdata, exp_rdata);
    check({tag, " err"}, 32'(rsp_err), 32'(exp_err));
    check({tag, " access_cnt"}, 32'(acc_cnt), exp_err ? 32'h0 : 32'h1);
    check({tag, " ready_low"}, 32'(req_ready), 32'h0);
    check({tag, " paddr_hold"}, paddr, addr);
    check({tag, " pwrite_hold"}, 32'(pwrite), 32'(wr));
    check({tag, " pwdata_hold"}, pwdata, wdata);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit chk;
`ifdef APBM_ADDR_CHECK_EN
    chk = 1'b1;
`else
    chk = 1'b0;
`endif
    preset    = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(posedge pclk);
    #1;
    check("rst req_ready", 32'(req_ready), 32'h1);
    check("rst psel", 32'(psel), 32'h0);
    check("rst penable", 32'(penable), 32'h0);
    check("rst pwrite", 32'(pwrite), 32'h0);
    check("rst paddr", paddr, 32'h0);
    check("rst pwdata", pwdata, 32'h0);
    check("rst rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst rsp_rdata", rsp_rdata, 32'h0);
    check("rst rsp_err", 32'(rsp_err), 32'h0);
    preset = 1'b0;

    do_cmd("rd4", 1'b0, 32'h4, 32'h0, 32'h5A5A_5555, 4, 1'b0, 1'b0);
    do_cmd("wr8", 1'b1, 32'h8, 32'hDEAD_BEEF, 32'h0, 3, 1'b0, 1'b0);
    do_cmd("rd8", 1'b0, 32'h8, 32'h0, 32'hDEAD_BEEF, 4, 1'b0, 1'b0);
    do_cmd("wr4_ro", 1'b1, 32'h4, 32'h1111_1111, 32'h0, 3, 1'b0, 1'b0);
    do_cmd("rd4_ro", 1'b0, 32'h4, 32'h0, 32'h5A5A_5555, 4, 1'b0, 1'b0);
    do_cmd("wr0", 1'b1, 32'h0, 32'h0000_000F, 32'h0, 3, 1'b0, 1'b0);
    do_cmd("rd0", 1'b0, 32'h0, 32'h0, 32'h0000_000F, 4, 1'b0, 1'b0);

    // Back-to-back reads with req_valid held high throughout.
    do_cmd("b2b_rdC", 1'b0, 32'hC, 32'h0, 32'hA5A5_0000, 4, 1'b0, 1'b1);
    do_cmd("b2b_rd10", 1'b0, 32'h10, 32'h0, 32'h0000_FFFF, 4, 1'b0, 1'b1);
    do_cmd("b2b_rd14", 1'b0, 32'h14, 32'h0, 32'h0, chk ? 1 : 4, chk, 1'b1);
    req_valid = 1'b0;

    // Reset during the ACCESS cycle of a write.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'hC;
    req_wdata = 32'h1234_5678;
    for (int i = 0; i < 8 && !req_ready; i++) begin
      @(posedge pclk); #1;
    end
    @(posedge pclk); #1;
    req_valid = 1'b0;
    check("abort setup psel", 32'(psel), 32'h1);
    check("abort setup penable", 32'(penable), 32'h0);
    @(posedge pclk); #1;
    check("abort access penable", 32'(penable), 32'h1);
    preset = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0;
    check("abort psel", 32'(psel), 32'h0);
    check("abort penable", 32'(penable), 32'h0);
    check("abort rsp_valid", 32'(rsp_valid), 32'h0);
    check("abort req_ready", 32'(req_ready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(posedge pclk); #1;
      check("abort no_rsp", 32'(rsp_valid), 32'h0);
    end
    do_cmd("rdC_after_abort", 1'b0, 32'hC, 32'h0, 32'hA5A5_0000, 4, 1'b0, 1'b0);

`ifdef APBM_ADDR_CHECK_EN
    do_cmd("err_rd14", 1'b0, 32'h14, 32'h0, 32'h0, 1, 1'b1, 1'b0);
    do_cmd("err_rd6", 1'b0, 32'h6, 32'h0, 32'h0, 1, 1'b1, 1'b0);
    do_cmd("ok_rd10", 1'b0, 32'h10, 32'h0, 32'h0000_FFFF, 4, 1'b0, 1'b0);
`endif

    @(posedge pclk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- APB master stage that sits directly upstream of the APB register slave.
- Converts a simple valid/ready command interface (from a test sequencer or CPU shim) into APB SETUP/ACCESS transfers.
- Returns write completions and read data on a response port.
- Accounts for the slave's registered read data, which becomes valid only after the ACCESS cycle; the slave has no pready.

Parameters:
ADDR_W, 32, width of req_addr/paddr
DATA_W, 32, width of data paths
RD_LAT, 1, cycles after ACCESS before prdata is valid (1..4)
MAX_ADDR, 'h10, highest legal register address (used only with optional feature)

Ports:
pclk  in  1  clock
preset  in  1  synchronous reset, active-high
req_valid  in  1  command valid
req_ready  out  1  command accepted when valid&ready at pclk edge
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle response pulse; no backpressure
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_err  out  1  request rejected (optional feature only)
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data

Behaviour:
- Clocking and reset: one clock, pclk. Reset preset is synchronous and active-high.
- Reset values: all outputs registered. While preset=1 the block is in state IDLE and every output is 0 except req_ready, which is 1.
- States: IDLE, SETUP, ACCESS, RDWAIT, RESP.
- IDLE:
  - req_ready=1.
  - When req_valid=1 at an edge, latch write/addr/wdata and go to SETUP.
- SETUP: psel=1, penable=0, paddr/pwrite/pwdata driven from the latched values; go to ACCESS.
- ACCESS:
  - psel=1, penable=1 for exactly one cycle; the slave acts at the closing edge.
  - A write goes to RESP.
  - A read goes to RDWAIT with its counter loaded to RD_LAT.
- RDWAIT:
  - psel=0, penable=0; counter decrements each cycle.
  - prdata is sampled into rsp_rdata at the edge where the counter reaches 0; then go to RESP.
- RESP:
  - rsp_valid=1 for one cycle, then IDLE.
  - Writes drive rsp_rdata=0.
- req_ready=0 in every state except IDLE.
- Timing, counting the acceptance edge as E0 (cycle n follows edge En-1):
  - write: SETUP in C1, ACCESS in C2, rsp_valid in C3 (4 cycles per write, including IDLE).
  - read: rsp_valid in C3+RD_LAT.
- paddr, pwrite and pwdata hold their last values after psel drops; they change only on acceptance or reset.
- penable is never high without psel. psel is never high for more than 2 consecutive cycles.
- Reset mid-transfer: abort to IDLE at that edge. No rsp_valid for the aborted command; psel/penable are 0 from the next cycle.
- req_valid held high continuously: the next command is accepted in the first IDLE cycle after RESP.
- Inputs are ignored outside IDLE; req_* may change freely.

Optional Feature:
- Macro APBM_ADDR_CHECK_EN.
- Defined:
  - In IDLE, an accepted request with req_addr[1:0]!=0 or req_addr>MAX_ADDR goes directly to RESP.
  - No SETUP/ACCESS is issued and psel stays 0.
  - The response is rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - Legal requests behave normally with rsp_err=0.
- Undefined: rsp_err is tied to 0 and every request goes onto the bus.

Decomposition:
- Shared package apb_pkg:
  - state enum typedef (IDLE..RESP);
  - APB_ADDR_W/APB_DATA_W constants;
  - slave register address constants (CNTRL='h0, REG1='h4, REG2='h8, REG3='hC, REG4='h10);
  - slave reset values, shared by the bench.
- No sub-module; the RDWAIT counter is inline. Single module.

Test Plan:
- Reset, then read 'h4 -> single SETUP/ACCESS pair; rsp_valid in C4 with rsp_rdata=32'h5A5A_5555 (RD_LAT=1).
- Write 'h8 data 32'hDEAD_BEEF, then read 'h8 -> write rsp_valid in C3, rsp_rdata=0; read returns 32'hDEAD_BEEF.
- Write 'h4 data 32'h1111_1111 (read-only in the slave), then read 'h4 -> 32'h5A5A_5555; read 'h0 after writing 'hF -> 32'h0000_000F.
- req_valid held high over 3 back-to-back reads ('hC, 'h10, 'h14) -> responses 32'hA5A5_0000, 32'h0000_FFFF, 0; req_ready high only in IDLE; psel gaps of at least 1 cycle.
- preset asserted during ACCESS of a write to 'hC -> no rsp_valid, psel=0 next cycle; subsequent read 'hC returns 32'hA5A5_0000.
- With APBM_ADDR_CHECK_EN, read 'h14 and read 'h6 -> psel never asserted; rsp_valid in C1 with rsp_err=1 and rsp_rdata=0.
